// File: rtl/board_move_engine.sv
// Move engine for the 3x3 sliding-tile board: press detection, legality check,
// blank/tile swap, saturating step count and solved-layout detection.
module board_move_engine #(
  parameter logic [35:0] INIT_BOARD   = 36'h870654321,
  parameter int unsigned INIT_BLANK   = 6,
  parameter logic [35:0] SOLVED_BOARD = 36'h087654321,
  parameter int unsigned STEP_MAX     = 999
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic [2:0]  dir_index,
  input  logic        I_restart,
  output logic [35:0] O_board,
  output logic [3:0]  O_blank_pos,
  output logic [9:0]  O_step_cnt,
  output logic        O_move_valid,
  output logic        O_move_reject,
  output logic        O_gameover
);

  typedef enum logic [2:0] {S_IDLE, S_EVAL, S_SWAP, S_CHECK, S_OVER} state_t;

  state_t      state, state_nxt;
  logic [2:0]  dir_prev, dir_lat;
  logic [3:0]  tgt, tgt_calc, tgt_val;
  logic [1:0]  row, col;
  logic        press, legal, solved;
  logic        ld_dir, ld_tgt, do_reject, do_swap, do_over;
  logic [35:0] board_swapped;

  assign press  = (dir_prev == 3'd0) && (dir_index >= 3'd1) && (dir_index <= 3'd4);
  assign solved = (O_board == SOLVED_BOARD);

  always_comb begin
    row = 2'd0;
    col = 2'd0;
    case (O_blank_pos)
      4'd0: begin row = 2'd0; col = 2'd0; end
      4'd1: begin row = 2'd0; col = 2'd1; end
      4'd2: begin row = 2'd0; col = 2'd2; end
      4'd3: begin row = 2'd1; col = 2'd0; end
      4'd4: begin row = 2'd1; col = 2'd1; end
      4'd5: begin row = 2'd1; col = 2'd2; end
      4'd6: begin row = 2'd2; col = 2'd0; end
      4'd7: begin row = 2'd2; col = 2'd1; end
      4'd8: begin row = 2'd2; col = 2'd2; end
      default: begin row = 2'd0; col = 2'd0; end
    endcase
  end

  // Target arithmetic only happens on the legal branch, so it can never wrap.
  always_comb begin
    legal    = 1'b0;
    tgt_calc = O_blank_pos;
    case (dir_lat)
      3'd1: if (row != 2'd2) begin legal = 1'b1; tgt_calc = O_blank_pos + 4'd3; end
      3'd2: if (row != 2'd0) begin legal = 1'b1; tgt_calc = O_blank_pos - 4'd3; end
      3'd3: if (col != 2'd2) begin legal = 1'b1; tgt_calc = O_blank_pos + 4'd1; end
      3'd4: if (col != 2'd0) begin legal = 1'b1; tgt_calc = O_blank_pos - 4'd1; end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    tgt_val       = '0;
    board_swapped = O_board;
    for (int unsigned k = 0; k < 9; k++) begin
      if (4'(k) == tgt) tgt_val = O_board[4*k +: 4];
    end
    for (int unsigned k = 0; k < 9; k++) begin
      if (4'(k) == O_blank_pos) board_swapped[4*k +: 4] = tgt_val;
      else if (4'(k) == tgt)    board_swapped[4*k +: 4] = '0;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (press) state_nxt = S_EVAL;
      S_EVAL:  state_nxt = legal ? S_SWAP : S_IDLE;
      S_SWAP:  state_nxt = S_CHECK;
      S_CHECK: state_nxt = solved ? S_OVER : S_IDLE;
      S_OVER:  state_nxt = S_OVER;
      default: state_nxt = S_IDLE;
    endcase
    if (I_restart) state_nxt = S_IDLE;
  end

  always_comb begin
    ld_dir    = 1'b0;
    ld_tgt    = 1'b0;
    do_reject = 1'b0;
    do_swap   = 1'b0;
    do_over   = 1'b0;
    case (state)
      S_IDLE:  ld_dir = press;
      S_EVAL:  begin ld_tgt = legal; do_reject = ~legal; end
      S_SWAP:  do_swap = 1'b1;
      S_CHECK: do_over = solved;
      default: ;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      dir_prev      <= '0;
      dir_lat       <= '0;
      tgt           <= '0;
      O_board       <= INIT_BOARD;
      O_blank_pos   <= 4'(INIT_BLANK);
      O_step_cnt    <= '0;
      O_move_valid  <= 1'b0;
      O_move_reject <= 1'b0;
      O_gameover    <= 1'b0;
    end else begin
      dir_prev      <= dir_index;
      O_move_valid  <= 1'b0;
      O_move_reject <= 1'b0;
      if (I_restart) begin
        O_board     <= INIT_BOARD;
        O_blank_pos <= 4'(INIT_BLANK);
        O_step_cnt  <= '0;
        O_gameover  <= 1'b0;
      end else begin
        if (ld_dir)    dir_lat <= dir_index;
        if (ld_tgt)    tgt <= tgt_calc;
        if (do_reject) O_move_reject <= 1'b1;
        if (do_swap) begin
          O_board      <= board_swapped;
          O_blank_pos  <= tgt;
          O_move_valid <= 1'b1;
          if (O_step_cnt < 10'(STEP_MAX)) O_step_cnt <= O_step_cnt + 10'd1;
        end
        if (do_over) O_gameover <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_board_move_engine.sv
// Bench for board_move_engine: event-scheduled board model checked every cycle,
// plus directed sequences with hand-computed literal expectations.
module tb_board_move_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        restart = 1'b0;
  logic [2:0]  dir = 3'd0;
  logic [35:0] board;
  logic [3:0]  blank;
  logic [9:0]  step;
  logic        mvalid, mreject, gover;

  board_move_engine #(
    .INIT_BOARD(36'h870654321), .INIT_BLANK(6),
    .SOLVED_BOARD(36'h087654321), .STEP_MAX(999)
  ) dut (
    .I_clk(clk), .I_rst_n(rst_n), .dir_index(dir), .I_restart(restart),
    .O_board(board), .O_blank_pos(blank), .O_step_cnt(step),
    .O_move_valid(mvalid), .O_move_reject(mreject), .O_gameover(gover)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit armed = 0;

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a press decides legality immediately and schedules its effects
  // at absolute edge numbers (reject +1, swap +2, solved check +3).
  int m_cell[9];
  int m_blank, m_step, m_cyc, m_prev, m_tgt;
  int swap_at, check_at, reject_at, free_at;
  bit m_valid, m_reject, m_over;

  function automatic void m_reload();
    m_cell  = '{1, 2, 3, 4, 5, 6, 0, 7, 8};
    m_blank = 6;
    m_step  = 0;
    m_over  = 0;
    m_valid = 0;
    m_reject = 0;
    swap_at = -1; check_at = -1; reject_at = -1; free_at = 0;
  endfunction

  function automatic bit m_solved();
    bit s = 1;
    for (int k = 0; k < 8; k++) if (m_cell[k] != k + 1) s = 0;
    if (m_cell[8] != 0) s = 0;
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reload();
      m_prev = 0;
    end else begin
      int r, c, t;
      bit legal;
      m_cyc++;
      m_valid  = 0;
      m_reject = 0;
      if (restart) begin
        m_reload();
      end else begin
        if (m_cyc == reject_at) m_reject = 1;
        if (m_cyc == swap_at) begin
          m_cell[m_blank] = m_cell[m_tgt];
          m_cell[m_tgt]   = 0;
          m_blank = m_tgt;
          if (m_step < 999) m_step++;
          m_valid = 1;
        end
        if (m_cyc == check_at && m_solved()) m_over = 1;
        if (!m_over && m_cyc >= free_at && m_prev == 0 && dir >= 1 && dir <= 4) begin
          r = m_blank / 3;
          c = m_blank % 3;
          legal = 0;
          t = m_blank;
          case (dir)
            3'd1: if (r < 2) begin legal = 1; t = m_blank + 3; end
            3'd2: if (r > 0) begin legal = 1; t = m_blank - 3; end
            3'd3: if (c < 2) begin legal = 1; t = m_blank + 1; end
            default: if (c > 0) begin legal = 1; t = m_blank - 1; end
          endcase
          if (legal) begin
            m_tgt = t; swap_at = m_cyc + 2; check_at = m_cyc + 3; free_at = m_cyc + 4;
          end else begin
            reject_at = m_cyc + 1; free_at = m_cyc + 2;
          end
        end
      end
      m_prev = int'(dir);
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      logic [35:0] eb;
      for (int k = 0; k < 9; k++) eb[4*k +: 4] = 4'(m_cell[k]);
      chk("cyc_board", board, eb);
      chk("cyc_blank", 36'(blank), 36'(m_blank));
      chk("cyc_step", 36'(step), 36'(m_step));
      chk("cyc_valid", 36'(mvalid), 36'(m_valid));
      chk("cyc_reject", 36'(mreject), 36'(m_reject));
      chk("cyc_gameover", 36'(gover), 36'(m_over));
    end
  end

  // Holds d for n rising edges, starting just after the next falling edge.
  task automatic set_dir(input logic [2:0] d, input int n);
    @(negedge clk); #1 dir = d;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] d);
    set_dir(d, 2);
    set_dir(3'd0, 5);
  endtask

  task automatic do_reset();
    @(negedge clk); #1 rst_n = 1'b0; dir = 3'd0; restart = 1'b0;
    #1;
    chk("rst_board", board, 36'h870654321);
    chk("rst_blank", 36'(blank), 36'd6);
    chk("rst_step", 36'(step), 36'd0);
    chk("rst_flags", 36'({mvalid, mreject, gover}), 36'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic press_expect_reject(input logic [2:0] d);
    @(negedge clk); #1 dir = d;
    @(negedge clk);
    chk("pre_reject", 36'(mreject), 36'd0);
    @(negedge clk);
    chk("reject_at_e1", 36'(mreject), 36'd1);
    #1 dir = 3'd0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    armed = 1;
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Solve from the initial layout with two left moves.
    press(3'd3);
    chk("solve1_board", board, 36'h807654321);
    chk("solve1_blank", 36'(blank), 36'd7);
    chk("solve1_step", 36'(step), 36'd1);
    chk("solve1_over", 36'(gover), 36'd0);
    press(3'd3);
    chk("solve2_board", board, 36'h087654321);
    chk("solve2_step", 36'(step), 36'd2);
    chk("solve2_over", 36'(gover), 36'd1);
    press(3'd4);
    press(3'd2);
    chk("over_board", board, 36'h087654321);
    chk("over_step", 36'(step), 36'd2);

    do_reset();

    press_expect_reject(3'd1);
    press_expect_reject(3'd4);
    chk("illegal_board", board, 36'h870654321);
    chk("illegal_step", 36'(step), 36'd0);

    set_dir(3'd2, 20);
    set_dir(3'd0, 3);
    chk("hold_blank", 36'(blank), 36'd3);
    chk("hold_step", 36'(step), 36'd1);
    chk("hold_board", board, 36'h874650321);

    set_dir(3'd3, 6);
    set_dir(3'd1, 6);
    set_dir(3'd0, 3);
    chk("nz_change_step", 36'(step), 36'd2);
    chk("nz_change_blank", 36'(blank), 36'd4);
    set_dir(3'd6, 4);
    set_dir(3'd0, 3);
    chk("code6_step", 36'(step), 36'd2);

    // Restart lands on the edge that would have committed the swap.
    do_reset();
    @(negedge clk); #1 dir = 3'd2;
    @(negedge clk); #1 dir = 3'd0;
    @(negedge clk); #1 restart = 1'b1;
    @(negedge clk);
    chk("rs_valid", 36'(mvalid), 36'd0);
    chk("rs_board", board, 36'h870654321);
    chk("rs_step", 36'(step), 36'd0);
    #1 restart = 1'b0;
    repeat (3) @(negedge clk);
    chk("rs_after_board", board, 36'h870654321);

    for (int i = 0; i < 501; i++) begin
      press(3'd2);
      press(3'd1);
    end
    chk("sat_step", 36'(step), 36'd999);
    chk("sat_blank", 36'(blank), 36'd6);

    for (int i = 0; i < 700; i++) begin
      int r;
      @(negedge clk); #1;
      r = $urandom_range(0, 9);
      if (r < 4)      dir = 3'd0;
      else if (r < 9) dir = 3'($urandom_range(1, 4));
      else            dir = 3'($urandom_range(5, 7));
      restart = ($urandom_range(0, 29) == 0);
      rst_n   = ($urandom_range(0, 149) != 0);
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    @(negedge clk); #1 rst_n = 1'b1; restart = 1'b0; dir = 3'd0;
    repeat (6) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/board_move_engine.md
# board_move_engine

Sequential move engine for the 3x3 sliding-tile board, directly downstream of the direction decoder. It consumes the level-coded `dir_index` and accepts one move per press. For each accepted move it checks legality, swaps the blank with its neighbour, counts steps, and detects the solved layout. `O_gameover` feeds back to the direction decoder, which freezes its output once the game is over.

## Interface
- `INIT_BOARD`, default `36'h870654321`: reset/restart layout; cell k (row-major, 0..8) in bits [4k+3:4k]; value 0 = blank.
- `INIT_BLANK`, default `6`: index of the blank cell in `INIT_BOARD`. Must be consistent with it.
- `SOLVED_BOARD`, default `36'h087654321`: target layout (1..8 in cells 0..7, blank in cell 8).
- `STEP_MAX`, default `999`: saturation value of the step counter.
- `I_clk` in 1: system clock, rising edge.
- `I_rst_n` in 1: asynchronous, active-low reset.
- `dir_index` in 3: 0 none, 1 up, 2 down, 3 left, 4 right; 5..7 ignored.
- `I_restart` in 1: synchronous reload of the game, level-sensitive.
- `O_board` out 36: current layout, same packing as `INIT_BOARD`.
- `O_blank_pos` out 4: blank cell index, 0..8.
- `O_step_cnt` out 10: accepted moves, saturating at `STEP_MAX`.
- `O_move_valid` out 1: one-cycle pulse when a swap is committed.
- `O_move_reject` out 1: one-cycle pulse when a press is illegal.
- `O_gameover` out 1: high once the board equals `SOLVED_BOARD`.

## Operation
- **Direction meaning.** Direction is the direction the tile moves into the blank.
  - up (1): the tile below the blank moves up. Legal if blank row < 2. New blank = b+3.
  - down (2): legal if row > 0. New blank = b-3.
  - left (3): legal if col < 2. New blank = b+1.
  - right (4): legal if col > 0. New blank = b-1.
  - Row = b/3 and col = b%3, from a 0..8 lookup; no divider.
- **Press detection.** `dir_prev` registers `dir_index` every cycle in every state. A press is `dir_prev==0 && dir_index` in 1..4, sampled only in IDLE. A direct nonzero-to-nonzero change is not a press. A press that arrives while the engine is not in IDLE is dropped.
- **FSM.**
  - IDLE: on a press, latch the direction and go to EVAL.
  - EVAL:
    - Illegal move: pulse `O_move_reject` and return to IDLE.
    - Legal move: compute the target cell t and go to SWAP.
  - SWAP: cell b takes cell t's value, and cell t takes 0. `O_blank_pos` becomes t. The step counter increments unless already at `STEP_MAX`. Pulse `O_move_valid`, then go to CHECK.
  - CHECK: if `O_board == SOLVED_BOARD`, set `O_gameover` and go to OVER; otherwise go to IDLE.
  - OVER: ignore all `dir_index` activity until restart.
- **Restart.** `I_restart` high at a clock edge, in any state, does all of the following:
  - reloads `INIT_BOARD` and `INIT_BLANK`;
  - clears `O_step_cnt` and `O_gameover`;
  - suppresses both pulses;
  - sends the FSM to IDLE.
  - Restart has priority over every in-flight move; a half-done move is never committed.
- **Width rules.**
  - Blank arithmetic is 4-bit and is only performed after the legality check, so no wrap is possible.
  - The step counter never exceeds `STEP_MAX`.
- **Reset.** On `I_rst_n` low, asynchronously:
  - `O_board` = `INIT_BOARD`, `O_blank_pos` = `INIT_BLANK`;
  - `O_step_cnt` = 0, `O_move_valid` = 0, `O_move_reject` = 0, `O_gameover` = 0;
  - `dir_prev` = 0, FSM = IDLE.
  - Reset mid-move discards the move.

## Timing
- Edge E0: press sampled in IDLE.
- Edge E1: EVAL. `O_move_reject` is high for the cycle after E1 if the move is illegal.
- Edge E2: board, blank and step counter updated. `O_move_valid` is high for the cycle after E2.
- Edge E3: `O_gameover` registered high if the board is solved.
- Throughput:
  - Legal move: 3 cycles busy (EVAL, SWAP, CHECK).
  - Illegal move: 1 cycle.
  - Minimum press interval: 4 cycles including the return to 0.
- Outputs are registered only, with no combinational path from `dir_index` to any output.
- A held button produces exactly one move.
- Because `dir_prev` updates while busy, a button already held when the engine returns to IDLE does not generate a move.

## Test plan
- **Reset.** Assert `I_rst_n`=0 mid-simulation.
  - Expect `O_board`=`36'h870654321`, `O_blank_pos`=6, `O_step_cnt`=0, all flags 0, asynchronously (before the next clock).
- **Solve.** Press left (3), release, press left again.
  - After the first press: board 1,2,3,4,5,6,7,0,8, `O_blank_pos`=7, step=1, one `O_move_valid` pulse at E2.
  - After the second press: `O_board`=`36'h087654321`, step=2, `O_gameover`=1 at E3.
  - Further presses: no change.
- **Illegal move.** From reset, press up (1) with the blank in row 2.
  - Expect one `O_move_reject` pulse at E1; board and step unchanged.
  - Then press right (4): blank 6→5? No — col 0 is illegal, so reject again.
- **Held key and invalid codes.**
  - Hold down (2) for 20 cycles: exactly one move, blank 6→3, step=1.
  - Drive 3→1 with no intervening 0: no move.
  - Drive code 6: ignored.
- **Restart and saturation.**
  - Assert `I_restart` in the SWAP cycle: board = `INIT_BOARD`, step=0, no `O_move_valid`.
  - Force step to `STEP_MAX` via alternating down/up moves: the counter stays at 999.
